// File: rtl/md_unit.sv
// md_unit: multiply/divide unit holding the HI/LO register pair.
//
// A start in IDLE with op MULT/MULTU (or DIV/DIVU when MDU_DIV_EN is
// defined) latches the operands and occupies the unit for MULT_CYCLES or
// DIV_CYCLES cycles. On the edge that ends the operation, {hi,lo} take the
// result and done pulses for one cycle. A start with op MTHI/MTLO in IDLE
// writes a into hi or lo at the next edge without going busy. Reserved
// opcodes are ignored. A start while busy is ignored.
//
// Optional feature macro: MDU_DIV_EN. When it is defined, the divide
// datapath is built. When it is undefined, op 2/3 act like reserved codes.
//
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high reset
//   start - operation request
//   op    - 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 reserved
//   a     - rs operand (multiplicand / dividend / MTHI-MTLO source)
//   b     - rt operand (multiplier / divisor)
//   busy  - operation in flight
//   done  - one-cycle pulse when hi/lo take a mult/div result
//   hi    - HI register
//   lo    - LO register
module md_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t         state, state_nx;
    logic [CW-1:0]  cnt, cnt_nx;
    logic           accept;
    logic           finish;
    logic           is_mul;
    logic           is_div;

    logic [31:0]    a_r, b_r;
    logic           sgn_r;

    logic [63:0]    res;
    logic           res_wr;

    assign is_mul = (op == 3'd0) || (op == 3'd1);
`ifdef MDU_DIV_EN
    assign is_div = (op == 3'd2) || (op == 3'd3);
`else
    assign is_div = 1'b0;
`endif

    assign busy = (state == BUSY);

    // The counter is loaded with N-1 so the unit spends exactly N cycles
    // in BUSY; the edge seen with cnt==0 is the one that ends the operation.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        accept   = 1'b0;
        finish   = 1'b0;
        case (state)
            IDLE: begin
                if (start && (is_mul || is_div)) begin
                    state_nx = BUSY;
                    accept   = 1'b1;
                    cnt_nx   = is_mul ? CW'(MULT_CYCLES - 1) : CW'(DIV_CYCLES - 1);
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    state_nx = IDLE;
                    finish   = 1'b1;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Multiply: operands are sign- or zero-extended to 64 bits so a single
    // 64x64 product truncated to 64 bits is exact for both flavours.
    logic [63:0] a_ext, b_ext, prod;
    assign a_ext = {{32{sgn_r & a_r[31]}}, a_r};
    assign b_ext = {{32{sgn_r & b_r[31]}}, b_r};
    assign prod  = a_ext * b_ext;

`ifdef MDU_DIV_EN
    logic        div_r;
    logic [31:0] a_mag, b_mag, q_mag, r_mag, q_fix, r_fix;

    // Signed divide is done on magnitudes, then the signs are restored:
    // quotient negative when operand signs differ, remainder follows the
    // dividend. 0x80000000 / -1 falls out as 0x80000000 rem 0.
    assign a_mag = (sgn_r && a_r[31]) ? (32'd0 - a_r) : a_r;
    assign b_mag = (sgn_r && b_r[31]) ? (32'd0 - b_r) : b_r;
    assign q_mag = (b_mag == '0) ? '0 : (a_mag / b_mag);
    assign r_mag = (b_mag == '0) ? '0 : (a_mag % b_mag);
    assign q_fix = (sgn_r && (a_r[31] ^ b_r[31])) ? (32'd0 - q_mag) : q_mag;
    assign r_fix = (sgn_r && a_r[31]) ? (32'd0 - r_mag) : r_mag;

    always_comb begin
        res    = prod;
        res_wr = 1'b1;
        if (div_r) begin
            res    = {r_fix, q_fix};
            res_wr = (b_r != '0);
        end
    end
`else
    always_comb begin
        res    = prod;
        res_wr = 1'b1;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            a_r   <= '0;
            b_r   <= '0;
            sgn_r <= 1'b0;
`ifdef MDU_DIV_EN
            div_r <= 1'b0;
`endif
        end else begin
            done <= finish;
            if (accept) begin
                a_r   <= a;
                b_r   <= b;
                sgn_r <= ~op[0];
`ifdef MDU_DIV_EN
                div_r <= op[1];
`endif
            end
            if (finish) begin
                if (res_wr) begin
                    hi <= res[63:32];
                    lo <= res[31:0];
                end
            end else if (state == IDLE && start) begin
                if (op == 3'd4) hi <= a;
                if (op == 3'd5) lo <= a;
            end
        end
    end

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Tracks the architectural effect of each accepted request: when it was
    // accepted, the cycle its result lands, and what that result is.
    logic [31:0] m_hi = '0, m_lo = '0;
    logic [31:0] r_hi, r_lo;
    logic        r_wr;
    bit          m_pend = 0;
    bit          m_done = 0;
    int          m_cyc = 0;
    int          m_end = 0;
    bit          div_en;

    initial begin
`ifdef MDU_DIV_EN
        div_en = 1;
`else
        div_en = 0;
`endif
    end

    always @(posedge clk) begin
        longint      sa, sb, sq, sr;
        logic [63:0] p;
        m_done = 0;
        if (reset) begin
            m_hi = '0; m_lo = '0; m_pend = 0;
        end else if (m_pend) begin
            if (m_cyc == m_end) begin
                if (r_wr) begin m_hi = r_hi; m_lo = r_lo; end
                m_done = 1;
                m_pend = 0;
            end
        end else if (start) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            case (op)
                3'd0: begin
                    p = 64'(sa * sb);
                    {r_hi, r_lo} = p; r_wr = 1; m_pend = 1; m_end = m_cyc + MC;
                end
                3'd1: begin
                    p = {32'd0, a} * {32'd0, b};
                    {r_hi, r_lo} = p; r_wr = 1; m_pend = 1; m_end = m_cyc + MC;
                end
                3'd2, 3'd3: if (div_en) begin
                    if (b == 0) begin
                        r_wr = 0;
                    end else if (op == 3'd2) begin
                        sq = sa / sb; sr = sa % sb;
                        r_lo = sq[31:0]; r_hi = sr[31:0]; r_wr = 1;
                    end else begin
                        r_lo = a / b; r_hi = a % b; r_wr = 1;
                    end
                    m_pend = 1; m_end = m_cyc + DC;
                end
                3'd4: m_hi = a;
                3'd5: m_lo = a;
                default: ;
            endcase
        end
        m_cyc++;
    end

    // Single compare process: every cycle, away from the active edge.
    bit cmp_en = 0;
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy", {31'd0, busy}, {31'd0, m_pend});
            chk("done", {31'd0, done}, {31'd0, m_done});
            chk("hi", hi, m_hi);
            chk("lo", lo, m_lo);
        end
    end

    // ---------------- stimulus helpers ----------------
    // Issue a one-cycle start; return at the negedge after the accepting
    // edge with the operand inputs already scrambled.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom);
    endtask

    // Count busy cycles until busy falls; returns at that negedge.
    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    int n;

    initial begin
        reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        @(negedge clk);
        do_reset();
        cmp_en = 1;

        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        chk("rst_busy", {31'd0, busy}, 32'd0);

        // MULT -2 * 3
        issue(3'd0, 32'hFFFFFFFE, 32'h00000003);
        count_busy(n);
        chk("mult_busy_cycles", n, MC);
        chk("mult_done", {31'd0, done}, 32'd1);
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFFA);
        chk("model_mult_lo", m_lo, 32'hFFFFFFFA);
        @(negedge clk);
        chk("done_one_cycle", {31'd0, done}, 32'd0);

        // MULTU max * max
        issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        count_busy(n);
        chk("multu_busy_cycles", n, MC);
        chk("multu_hi", hi, 32'hFFFFFFFE);
        chk("multu_lo", lo, 32'h00000001);
        chk("model_multu_hi", m_hi, 32'hFFFFFFFE);

        // MULT, then MTHI in busy cycle 2 is ignored
        @(negedge clk);
        issue(3'd0, 32'h00000007, 32'hFFFFFFFD);
        @(negedge clk);
        issue(3'd4, 32'h12345678, 32'h0);
        count_busy(n);
        chk("mult_ignore_hi", hi, 32'hFFFFFFFF);
        chk("mult_ignore_lo", lo, 32'hFFFFFFEB);

        // MTLO in idle
        @(negedge clk);
        issue(3'd5, 32'hCAFEBABE, 32'h0);
        chk("mtlo_lo", lo, 32'hCAFEBABE);
        chk("mtlo_hi_hold", hi, 32'hFFFFFFFF);
        chk("mtlo_no_busy", {31'd0, busy}, 32'd0);

        // Reserved op
        issue(3'd6, 32'h11111111, 32'h2);
        chk("rsvd_no_busy", {31'd0, busy}, 32'd0);
        chk("rsvd_lo_hold", lo, 32'hCAFEBABE);

`ifdef MDU_DIV_EN
        issue(3'd2, 32'hFFFFFFF9, 32'h00000002);
        count_busy(n);
        chk("div_busy_cycles", n, DC);
        chk("div_lo", lo, 32'hFFFFFFFD);
        chk("div_hi", hi, 32'hFFFFFFFF);
        @(negedge clk);
        issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
        count_busy(n);
        chk("div_ovf_lo", lo, 32'h80000000);
        chk("div_ovf_hi", hi, 32'h00000000);
        @(negedge clk);
        issue(3'd3, 32'h00000007, 32'h00000000);
        count_busy(n);
        chk("divu0_busy_cycles", n, DC);
        chk("divu0_done", {31'd0, done}, 32'd1);
        chk("divu0_lo_hold", lo, 32'h80000000);
        chk("divu0_hi_hold", hi, 32'h00000000);
        @(negedge clk);
        issue(3'd2, 32'h00000064, 32'h00000007);
`else
        issue(3'd2, 32'hFFFFFFF9, 32'h00000002);
        chk("nodiv_busy", {31'd0, busy}, 32'd0);
        chk("nodiv_lo_hold", lo, 32'hCAFEBABE);
        issue(3'd0, 32'h00000064, 32'h00000007);
`endif
        // Reset in busy cycle 4 aborts with no done
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_hi", hi, 32'h0);
        chk("abort_lo", lo, 32'h0);
        repeat (12) begin
            @(negedge clk);
            chk("abort_no_done", {31'd0, done}, 32'd0);
        end

        // Randomized traffic; starts while busy and rare resets included.
        for (int i = 0; i < 3000; i++) begin
            int unsigned sel;
            reset = ($urandom_range(0, 199) == 0);
            start = ($urandom_range(0, 2) == 0);
            op    = 3'($urandom);
            sel   = $urandom_range(0, 7);
            a     = (sel == 0) ? 32'h80000000 : (sel == 1) ? 32'hFFFFFFFF : $urandom;
            sel   = $urandom_range(0, 7);
            b     = (sel == 0) ? 32'h0 : (sel == 1) ? 32'hFFFFFFFF : (sel == 2) ? 32'($urandom_range(1, 9)) : $urandom;
            @(negedge clk);
        end
        reset = 1'b0; start = 1'b0;
        repeat (15) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter MULT_CYCLES, default 5: the number of busy cycles for a multiply.
REQ-003 Parameter DIV_CYCLES, default 10: the number of busy cycles for a divide.
REQ-004 Port clk, input, 1 bit: the rising-edge clock.
REQ-005 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port start, input, 1 bit: operation request, qualified by clk.
REQ-007 Port op, input, 3 bits: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; codes 6 and 7 are reserved.
REQ-008 Port a, input, 32 bits: rs operand (multiplicand or dividend; the MTHI/MTLO source).
REQ-009 Port b, input, 32 bits: rt operand (multiplier or divisor).
REQ-010 Port busy, output, 1 bit: an operation is in flight; the hazard unit stalls mfhi/mflo and new md instructions while it is high.
REQ-011 Port done, output, 1 bit: one-cycle pulse when hi and lo take a mult/div result.
REQ-012 Port hi, output, 32 bits: the HI register; it feeds the writeback select mux.
REQ-013 Port lo, output, 32 bits: the LO register; it feeds the writeback select mux.

Function
REQ-014 The FSM SHALL have two states, IDLE and BUSY, plus a cycle counter sized for max(MULT_CYCLES, DIV_CYCLES).
REQ-015 In IDLE, start with op 0-3 SHALL latch a, b and op and enter BUSY on the next edge; busy SHALL go high in the cycle after the start cycle.
REQ-016 The unit SHALL stay in BUSY for exactly MULT_CYCLES (op 0/1) or DIV_CYCLES (op 2/3) cycles.
REQ-017 On the edge that ends BUSY, hi/lo SHALL update, busy SHALL fall and done SHALL be high for that one following cycle.
REQ-018 start while busy=1 SHALL be ignored, and the in-flight operation SHALL be unaffected.
REQ-019 MTHI/MTLO with start in IDLE SHALL write a into hi or lo at the next edge, with no busy and no done; the other register SHALL hold.
REQ-020 Reserved op codes SHALL be ignored.
REQ-021 MULT SHALL produce the signed 64-bit product of a and b; MULTU SHALL produce the unsigned 64-bit product; {hi,lo} SHALL equal the full product.
REQ-022 DIV SHALL be signed and truncate toward zero: lo = quotient, hi = remainder, remainder sign = dividend sign; DIVU SHALL be unsigned.
REQ-023 DIV of 0x80000000 by 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0x00000000.
REQ-024 Divisor zero (DIV/DIVU) SHALL still take DIV_CYCLES and pulse done, and hi/lo SHALL remain unchanged.
REQ-025 Operands SHALL be sampled only at the accepting edge; later changes on a and b SHALL have no effect.
REQ-026 hi and lo SHALL be registered outputs with no combinational path from the inputs.

Reset
REQ-027 When reset=1 at an edge: state SHALL become IDLE, the counter 0, busy 0, done 0, hi 0x00000000 and lo 0x00000000.
REQ-028 Reset SHALL have priority over start, and reset during BUSY SHALL abort the operation with no done pulse.

Configuration
REQ-029 Macro MDU_DIV_EN defined: DIV/DIVU SHALL be implemented per REQ-022 to REQ-024.
REQ-030 Macro MDU_DIV_EN undefined: the divide datapath SHALL be absent; op 2/3 SHALL be treated as reserved (ignored, no busy, no done, hi/lo hold).

Verification
REQ-031 Reset, then MULT a=0xFFFFFFFE b=0x00000003 -> busy high for 5 cycles, then done pulse, hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-032 MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 after 5 busy cycles.
REQ-033 DIV a=0xFFFFFFF9 (-7) b=2 -> after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=7 b=0 -> hi/lo unchanged, done still pulses.
REQ-034 MULT accepted, then a second start MTHI a=0x12345678 in the busy cycle 2 -> ignored; the final hi/lo hold the MULT result only.
REQ-035 MTLO a=0xCAFEBABE in IDLE -> lo=0xCAFEBABE next cycle, busy stays 0, hi unchanged.
REQ-036 DIV started, reset asserted in the busy cycle 4 -> next cycle busy=0, hi=lo=0, no done pulse; with MDU_DIV_EN undefined, DIV start -> busy stays 0.
